alu_fib_sequencer: RTL
======================

ALU_FIB_SEQUENCER -- requirements
Module: alu_fib_sequencer

Interface
REQ-001 SHALL have parameter ADD_OPCODE, default 8'b00000101, meaning the ALU add opcode.
REQ-002 SHALL have parameter CARRY_BIT, default 3, meaning the index of the carry flag in alu_flags.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a run; sampled only in IDLE.
REQ-006 count  input  6  number of terms requested; captured on accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 alu_a  output  16  ALU operand A.
REQ-009 alu_b  output  16  ALU operand B.
REQ-010 alu_opcode  output  8  ALU opcode.
REQ-011 alu_cin  output  1  ALU carry-in; always 0.
REQ-012 alu_c  input  16  ALU result; combinational from alu_a/alu_b/alu_opcode.
REQ-013 alu_flags  input  5  ALU flags; bit CARRY_BIT is unsigned carry-out.
REQ-014 out_valid  output  1  out_data holds a term.
REQ-015 out_ready  input  1  consumer accepts the term when out_valid and out_ready are both high.
REQ-016 out_data  output  16  Fibonacci term.
REQ-017 done  output  1  one-cycle pulse at run end.
REQ-018 overflow  output  1  sticky; set when a run ends on carry; cleared on next accepted start.

Function
REQ-019 SHALL use states IDLE, SEED, ISSUE, CAPTURE, EMIT, FINISH.
REQ-020 SHALL leave IDLE only on start=1; it SHALL latch count, clear overflow, set prev=0, cur=1, emitted=0, and go to SEED.
REQ-021 SHALL, in SEED, go to FINISH if emitted==count; otherwise present emitted==0 ? 0 : 1 on out_data with out_valid=1, and advance emitted on handshake.
REQ-022 SHALL leave SEED for ISSUE once emitted==2 and count>2.
REQ-023 SHALL, in ISSUE, drive alu_a=prev, alu_b=cur, alu_opcode=ADD_OPCODE; the next state SHALL be CAPTURE.
REQ-024 SHALL, in CAPTURE, hold the same ALU inputs and register alu_c and alu_flags[CARRY_BIT] (one-cycle ALU latency budget).
REQ-025 SHALL, on captured carry=1, set overflow, emit nothing, and go to FINISH.
REQ-026 SHALL, on carry=0, set prev=cur, cur=sum, and go to EMIT.
REQ-027 SHALL, in EMIT, hold out_valid=1 with out_data=cur until handshake; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, on the EMIT handshake, increment emitted and go to FINISH if emitted+1==count, else to ISSUE.
REQ-029 SHALL, in FINISH, pulse done for exactly one cycle and return to IDLE.
REQ-030 SHALL drive alu_a=0, alu_b=0, alu_opcode=ADD_OPCODE outside ISSUE/CAPTURE.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL, for count=0, emit no terms and assert done two cycles after start.

Reset
REQ-033 SHALL, on rst_n=0 at any time including mid-run, go to IDLE with busy=0, out_valid=0, out_data=0, done=0, overflow=0, alu_a=0, alu_b=0, alu_cin=0, prev=0, cur=0, emitted=0.
REQ-034 SHALL accept no start while rst_n=0; the first possible start is on the first edge after deassertion.

Structure
REQ-035 SHALL take the opcode constants (ADD=8'b00000101) and flag bit indices (carry=3) from shared package alu_pkg, which the ALU uses as well.
REQ-036 SHALL be one module; no sub-module is required.

Verification
REQ-037 count=5, out_ready=1 -> out_data 0,1,1,2,3; done pulses once; overflow=0.
REQ-038 count=0 -> no out_valid; done two cycles after start.
REQ-039 count=30 -> 25 terms F0..F24, the last being 46368 (16'hB520); then done with overflow=1 (F25=75025 carries).
REQ-040 count=4, out_ready low 3 cycles during the third term -> out_data=1 held stable; sequence 0,1,1,2 intact.
REQ-041 start pulsed while busy -> ignored; after done, a new start with count=3 -> 0,1,1 and overflow cleared.
REQ-042 rst_n low during EMIT of term 2 -> all outputs zero immediately; next start with count=2 -> 0,1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag bit positions shared by the ALU and its sequencers.
package alu_pkg;

   localparam int ALU_DATA_W = 16;
   localparam int ALU_FLAGS_W = 5;

   localparam logic [7:0] ALU_OP_ADD = 8'b00000101;

   localparam int ALU_FLAG_ZERO = 0;
   localparam int ALU_FLAG_CARRY = 3;

endpackage

// File: rtl/alu_fib_sequencer.sv
// alu_fib_sequencer: streams Fibonacci terms computed on an external ALU, stopping on count or carry-out.
// Latency: two seed terms one per handshake, then issue/capture/emit per term; count=0 gives done two cycles after start.
// Backpressure: out_valid holds with stable out_data until out_ready; the sequence stalls while the consumer is not ready.
module alu_fib_sequencer
   import alu_pkg::*;
#(
   parameter logic [7:0] ADD_OPCODE = ALU_OP_ADD,
   parameter int CARRY_BIT = ALU_FLAG_CARRY
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [5:0]             count,
   output logic                   busy,
   output logic [ALU_DATA_W-1:0]  alu_a,
   output logic [ALU_DATA_W-1:0]  alu_b,
   output logic [7:0]             alu_opcode,
   output logic                   alu_cin,
   input  logic [ALU_DATA_W-1:0]  alu_c,
   input  logic [ALU_FLAGS_W-1:0] alu_flags,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ALU_DATA_W-1:0]  out_data,
   output logic                   done,
   output logic                   overflow
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEED    = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_EMIT    = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;

   logic [2:0]            state;
   logic [5:0]            count_q;
   logic [5:0]            emitted;
   logic [ALU_DATA_W-1:0] prev;
   logic [ALU_DATA_W-1:0] cur;
   logic                  overflow_q;
   logic                  alu_active;
   logic                  hs;
   logic                  unused_flags;

   // Only the carry flag steers the run; the other flags are ALU-internal detail.
   assign unused_flags = ^alu_flags;

   assign alu_active = (state == S_ISSUE) || (state == S_CAPTURE);
   assign alu_a      = alu_active ? prev : '0;
   assign alu_b      = alu_active ? cur  : '0;
   assign alu_opcode = ADD_OPCODE;
   assign alu_cin    = 1'b0;

   assign busy     = (state != S_IDLE);
   assign done     = (state == S_FINISH);
   assign overflow = overflow_q;
   assign hs       = out_valid && out_ready;

   // F0 and F1 come straight from the seed state; later terms come from cur.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      if (state == S_SEED && emitted != count_q && emitted < 6'd2) begin
         out_valid = 1'b1;
         out_data  = (emitted == 6'd0) ? 16'd0 : 16'd1;
      end else if (state == S_EMIT) begin
         out_valid = 1'b1;
         out_data  = cur;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         count_q    <= '0;
         emitted    <= '0;
         prev       <= '0;
         cur        <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  count_q    <= count;
                  overflow_q <= 1'b0;
                  prev       <= '0;
                  cur        <= 16'd1;
                  emitted    <= '0;
                  state      <= S_SEED;
               end
            end
            S_SEED: begin
               if (emitted == count_q) begin
                  state <= S_FINISH;
               end else if (hs) begin
                  emitted <= emitted + 6'd1;
                  if (emitted == 6'd1 && count_q > 6'd2)
                     state <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_CAPTURE;
            S_CAPTURE: begin
               // A carry means the next term no longer fits; stop without emitting it.
               if (alu_flags[CARRY_BIT]) begin
                  overflow_q <= 1'b1;
                  state      <= S_FINISH;
               end else begin
                  prev  <= cur;
                  cur   <= alu_c;
                  state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (hs) begin
                  emitted <= emitted + 6'd1;
                  state   <= (emitted + 6'd1 == count_q) ? S_FINISH : S_ISSUE;
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule
